// File: rtl/led_pwm_pkg.sv
// Shared types and constants for the LED PWM bank: channel modes,
// breathe direction and the blink frame-counter width.
package led_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STATIC  = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } led_mode_e;

  typedef enum logic {
    BR_UP   = 1'b0,
    BR_DOWN = 1'b1
  } br_state_e;

  localparam int unsigned BLINK_LOG2 = 6;

endpackage

// File: rtl/led_pwm_chan.sv
// One LED channel: pending/active configuration, breathe FSM (present only
// with LED_PWM_BREATHE_EN defined) and registered PWM compare.
module led_pwm_chan
  import led_pwm_pkg::*;
#(
  parameter int unsigned PWM_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [PWM_W-1:0] wr_duty_i,
  input  logic [1:0]       wr_mode_i,
  input  logic             frame_tick_i,
  input  logic             blink_on_i,
  input  logic [PWM_W-1:0] pwm_cnt_i,
  output logic             pwm_o
);

  logic [PWM_W-1:0] pend_duty_q, act_duty_q, eff_duty;
  led_mode_e        pend_mode_q, act_mode_q;
  logic             pwm_q;

  // Active settings only move on the frame boundary so a frame never glitches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_duty_q <= '0;
      pend_mode_q <= MODE_OFF;
      act_duty_q  <= '0;
      act_mode_q  <= MODE_OFF;
    end else begin
      if (wr_en_i) begin
        pend_duty_q <= wr_duty_i;
        pend_mode_q <= led_mode_e'(wr_mode_i);
      end
      if (frame_tick_i) begin
        act_duty_q <= pend_duty_q;
        act_mode_q <= pend_mode_q;
      end
    end
  end

`ifdef LED_PWM_BREATHE_EN
  logic [PWM_W-1:0] level_q, level_d;
  br_state_e        state_q, state_d;

  always_comb begin
    level_d = level_q;
    state_d = state_q;
    if (frame_tick_i) begin
      if (pend_mode_q != act_mode_q) begin
        level_d = '0;
        state_d = BR_UP;
      end else if (act_mode_q == MODE_BREATHE) begin
        if (state_q == BR_UP) begin
          if (level_q >= act_duty_q) begin
            state_d = BR_DOWN;
            level_d = act_duty_q;
          end else begin
            level_d = level_q + PWM_W'(1);
          end
        end else begin
          if (level_q == '0) begin
            state_d = BR_UP;
          end else begin
            level_d = level_q - PWM_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= '0;
      state_q <= BR_UP;
    end else begin
      level_q <= level_d;
      state_q <= state_d;
    end
  end
`endif

  always_comb begin
    eff_duty = '0;
    case (act_mode_q)
      MODE_OFF:     eff_duty = '0;
      MODE_STATIC:  eff_duty = act_duty_q;
      MODE_BLINK:   eff_duty = blink_on_i ? act_duty_q : '0;
`ifdef LED_PWM_BREATHE_EN
      MODE_BREATHE: eff_duty = level_q;
`else
      MODE_BREATHE: eff_duty = act_duty_q;
`endif
      default:      eff_duty = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= (pwm_cnt_i < eff_duty);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/led_pwm_bank.sv
// Multi-channel LED PWM bank: shared prescaler, PWM counter and blink counter
// feeding NCH channels. Breathe mode is enabled by defining LED_PWM_BREATHE_EN.
module led_pwm_bank
  import led_pwm_pkg::*;
#(
  parameter  int unsigned NCH   = 3,
  parameter  int unsigned PWM_W = 8,
  parameter  int unsigned PRE_W = 16,
  localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PRE_W-1:0] prescale,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [PWM_W-1:0] wr_duty,
  input  logic [1:0]       wr_mode,
  output logic [NCH-1:0]   pwm_out,
  output logic             frame_tick
);

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [PWM_W-1:0]      cnt_q, cnt_d;
  logic [BLINK_LOG2-1:0] blink_q, blink_d;
  logic                  tick;
  logic [NCH-1:0]        ch_wr;

  // >= rather than == so lowering prescale mid-count never stalls for a full wrap.
  always_comb begin
    tick       = (pre_q >= prescale);
    pre_d      = tick ? '0 : pre_q + PRE_W'(1);
    cnt_d      = tick ? cnt_q + PWM_W'(1) : cnt_q;
    frame_tick = tick && (cnt_q == '1);
    blink_d    = frame_tick ? blink_q + BLINK_LOG2'(1) : blink_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      blink_q <= '0;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign ch_wr[i] = wr_en && (wr_ch == CH_W'(i));

    led_pwm_chan #(
      .PWM_W(PWM_W)
    ) u_chan (
      .clk_i       (clk),
      .rst_i       (rst),
      .wr_en_i     (ch_wr[i]),
      .wr_duty_i   (wr_duty),
      .wr_mode_i   (wr_mode),
      .frame_tick_i(frame_tick),
      .blink_on_i  (blink_q[BLINK_LOG2-1]),
      .pwm_cnt_i   (cnt_q),
      .pwm_o       (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed scoreboard bench for led_pwm_bank: per-frame high-count per channel
// and frame_tick position, plus reset behaviour.
module tb_led_pwm_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] prescale;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [7:0]  wr_duty;
  logic [1:0]  wr_mode;
  logic [2:0]  pwm_out;
  logic        frame_tick;

  led_pwm_bank #(
    .NCH  (3),
    .PWM_W(8),
    .PRE_W(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prescale  (prescale),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_duty   (wr_duty),
    .wr_mode   (wr_mode),
    .pwm_out   (pwm_out),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   synced   = 1'b0;
  int   br[13];

  task automatic push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input int obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      e.tag = "scoreboard_empty";
      e.val = -1;
    end else begin
      e = sb.pop_front();
    end
    assert (obs === e.val) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
  endtask

  task automatic write(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] duty);
    @(negedge clk);
    wr_en = 1'b1; wr_ch = ch; wr_mode = mode; wr_duty = duty;
    @(negedge clk);
    wr_en = 1'b0;
    synced = 1'b0;
  endtask

  // wr_at: -2 no write, -1 write on the frame_tick cycle (unsynced only),
  // k >= 0 write at window cycle k. Counts highs over one full output frame.
  task automatic measure(input int wr_at, input logic [1:0] ch, input logic [1:0] mode,
                         input logic [7:0] duty, input int e0, input int e1, input int e2,
                         input string tag);
    int cnt[3];
    int tpos, tnum;
    bit found;
    cnt  = '{0, 0, 0};
    tpos = -1;
    tnum = 0;
    if (!synced) begin
      found = 1'b0;
      for (int n = 0; n < 2000 && !found; n++) begin
        @(negedge clk);
        found = frame_tick;
      end
      push({tag, "_sync"}, 1);
      check(int'(found));
      if (wr_at == -1) begin
        wr_en = 1'b1; wr_ch = ch; wr_mode = mode; wr_duty = duty;
      end
      @(negedge clk);
      wr_en = 1'b0;
    end
    push({tag, "_ch0"}, e0);
    push({tag, "_ch1"}, e1);
    push({tag, "_ch2"}, e2);
    push({tag, "_tickpos"}, 254);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (i == wr_at) begin
        wr_en = 1'b1; wr_ch = ch; wr_mode = mode; wr_duty = duty;
      end else begin
        wr_en = 1'b0;
      end
      for (int c = 0; c < 3; c++) cnt[c] += int'(pwm_out[c]);
      if (frame_tick) begin
        tnum++;
        tpos = i;
      end
    end
    wr_en  = 1'b0;
    synced = 1'b1;
    check(cnt[0]);
    check(cnt[1]);
    check(cnt[2]);
    check((tnum == 1) ? tpos : -1);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push({tag, "_pwm"}, 0);
    check(int'(pwm_out));
    push({tag, "_ftick"}, 0);
    check(int'(frame_tick));
    rst    = 1'b0;
    synced = 1'b0;
  endtask

  initial begin
    int  n;
    bit  hi;
    rst = 1'b1; prescale = '0; wr_en = 1'b0; wr_ch = '0; wr_duty = '0; wr_mode = '0;
`ifdef LED_PWM_BREATHE_EN
    br = '{0, 1, 2, 3, 4, 4, 3, 2, 1, 0, 0, 1, 2};
`else
    br = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
`endif

    repeat (3) @(negedge clk);
    push("init_pwm", 0);   check(int'(pwm_out));
    push("init_ftick", 0); check(int'(frame_tick));
    rst = 1'b0;

    // STATIC 128 / 0 / 255
    write(2'd0, 2'b01, 8'd128);
    write(2'd2, 2'b01, 8'd255);
    measure(-2, 2'd0, 2'b00, 8'd0, 128, 0, 255, "static");

    // mid-frame write is held until the next boundary
    measure(99, 2'd1, 2'b01, 8'd64, 128, 0, 255, "midwr_cur");
    measure(-2, 2'd0, 2'b00, 8'd0, 128, 64, 255, "midwr_next");

    // write on the frame_tick cycle lands one frame later
    synced = 1'b0;
    measure(-1, 2'd1, 2'b01, 8'd32, 128, 64, 255, "tickwr_f1");
    measure(-2, 2'd0, 2'b00, 8'd0, 128, 32, 255, "tickwr_f2");

    // out-of-range channel is ignored
    write(2'd3, 2'b00, 8'd0);
    measure(-2, 2'd0, 2'b00, 8'd0, 128, 32, 255, "badch");

    // breathe duty 4 on ch2, breathe duty 0 on ch1 stays dark
    write(2'd1, 2'b11, 8'd0);
    write(2'd2, 2'b11, 8'd4);
    for (int k = 0; k < 13; k++)
      measure(-2, 2'd0, 2'b00, 8'd0, 128, 0, br[k], $sformatf("breathe%0d", k));

    // blink 200: frame k after reset sees blink count k mod 64
    do_reset("rst_blink");
    write(2'd0, 2'b10, 8'd200);
    for (int k = 1; k <= 66; k++)
      measure(-2, 2'd0, 2'b00, 8'd0, ((k % 64) >= 32) ? 200 : 0, 0, 0, $sformatf("blink%0d", k));

    // reset mid-frame with prescale=1
    write(2'd0, 2'b01, 8'd255);
    prescale = 16'd1;
    repeat (1200) @(negedge clk);
    hi = 1'b0;
    for (int k = 0; k < 20 && !hi; k++) begin
      @(negedge clk);
      hi = pwm_out[0];
    end
    push("pre_rst_high", 1);
    check(int'(hi));
    rst = 1'b1;
    @(negedge clk);
    push("rst_mid_pwm", 0);   check(int'(pwm_out));
    push("rst_mid_ftick", 0); check(int'(frame_tick));
    rst = 1'b0;
    n   = 1;
    hi  = 1'b0;
    while (!hi && n < 2000) begin
      @(negedge clk);
      n++;
      hi = frame_tick;
    end
    push("rst_mid_first_tick", 512);
    check(n);

    prescale = 16'd0;
    synced   = 1'b0;
    measure(-2, 2'd0, 2'b00, 8'd0, 0, 0, 0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
